// File: rtl/mem_access_unit_pkg.sv
// Shared widths and FSM state encoding for the memory access unit.
package mem_access_unit_pkg;

  localparam int MAU_ADDR_W  = 8;
  localparam int MAU_DATA_W  = 16;
  localparam int MAU_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } mau_state_e;

  function automatic int mau_ctr_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Main-memory en/ack bus between the access unit (master) and memory (slave).
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int AW = MAU_ADDR_W,
  parameter int DW = MAU_DATA_W
) ();

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_en;
  logic          mem_we;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_en, mem_we,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_en, mem_we,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_access_unit_timeout_ctr.sv
// Saturating wait counter for the ACCESS state; flags expiry at TIMEOUT-1.
module mau_timeout_ctr
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = MAU_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW   = mau_ctr_width(TIMEOUT);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = {CW{1'b1}};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == TERM);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage: runs one read/write per request over en/ack and owns the MBR.
// state  | meaning
// IDLE   | waiting for rd/wr request; ld_mbr_acc loads MBR here only
// ACCESS | mem_en high, waiting for mem_ack or timeout
// DONE   | one-cycle done pulse
// ERR    | one-cycle err pulse (timeout or rd&wr together)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = MAU_ADDR_W,
  parameter int DATA_W  = MAU_DATA_W,
  parameter int TIMEOUT = MAU_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_req_i,
  input  logic                wr_req_i,
  input  logic                ld_mbr_acc_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   acc_i,
  mem_access_unit_if.master   mem_if,
  output logic [DATA_W-1:0]   mbr_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  mau_state_e        state_q;
  logic [DATA_W-1:0] mbr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              expire;
  logic              ctr_clr;
  logic              ctr_en;

  // Counter is held at zero outside ACCESS, so every accept starts from 0.
  assign ctr_clr = (state_q != ST_ACCESS);
  assign ctr_en  = (state_q == ST_ACCESS) && !mem_if.mem_ack;

  mau_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mbr_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_req_i && wr_req_i) begin
            state_q <= ST_ERR;
          end else if (rd_req_i || wr_req_i) begin
            state_q <= ST_ACCESS;
            addr_q  <= addr_i;
            we_q    <= wr_req_i;
          end else if (ld_mbr_acc_i) begin
            mbr_q <= acc_i;
          end
        end
        ST_ACCESS: begin
          if (mem_if.mem_ack) begin
            state_q <= ST_DONE;
            if (!we_q) begin
              mbr_q <= mem_if.mem_rdata;
            end
          end else if (expire) begin
            state_q <= ST_ERR;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register, so reset drops them asynchronously.
  assign mem_if.mem_en    = (state_q == ST_ACCESS);
  assign mem_if.mem_we    = we_q;
  assign mem_if.mem_addr  = addr_q;
  assign mem_if.mem_wdata = mbr_q;

  assign mbr_o  = mbr_q;
  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign err_o  = (state_q == ST_ERR);

endmodule
